vga_timing_engine: RTL and testbench
====================================

Name: vga_timing_engine

Overview:
Parametrised successor of the fixed-mode VGA timing generator. Every horizontal and vertical timing segment and both sync polarities are parameters. Adds a synchronous enable/restart, line and frame strobes, and a vblank flag. A configurable delay pipeline on sync and data-enable keeps them aligned with downstream pixel pipelines (frame-buffer read, sprite mixing). Sits between the pixel clock domain and the pixel source and DAC/VGA pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level (0 = active-low)
SYNC_DELAY, 2, extra pipeline stages on hsync_d/vsync_d/de_d (0 allowed)

Derived values:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- H_W = $clog2(H_TOTAL); V_W = $clog2(V_TOTAL).

Ports:
clk  in  1  pixel clock
reset  in  1  reset, asynchronous, active-high
enable  in  1  run when 1; when 0, synchronously restarts at (0,0) with outputs blanked
next_col  out  H_W  column that will be presented on the next cycle
next_row  out  V_W  row that will be presented on the next cycle
visible_next  out  1  next_col<H_ACTIVE && next_row<V_ACTIVE (combinational)
col  out  H_W  current column (registered)
row  out  V_W  current row (registered)
visible  out  1  current pixel is in the active area
hsync  out  1  horizontal sync, polarity HS_POL
vsync  out  1  vertical sync, polarity VS_POL
line_start  out  1  one-cycle pulse when col==0
frame_start  out  1  one-cycle pulse when col==0 && row==0
vblank  out  1  row>=V_ACTIVE
hsync_d  out  1  hsync delayed SYNC_DELAY cycles
vsync_d  out  1  vsync delayed SYNC_DELAY cycles
de_d  out  1  visible delayed SYNC_DELAY cycles

Behaviour:
- Segment order per axis: active [0, ACTIVE-1], front porch, sync [ACTIVE+FP, ACTIVE+FP+SYNC-1], back porch, then wrap.
- Next counters, on each clk edge:
  - enable=0: next_col, next_row <= 0.
  - else if next_col==H_TOTAL-1: next_col <= 0; next_row <= (next_row==V_TOTAL-1) ? 0 : next_row+1.
  - else: next_col+1.
  - Counters never reach H_TOTAL/V_TOTAL (wrap is on TOTAL-1, not TOTAL).
- Presented stage, one cycle behind the next counters (latency exactly 1):
  - enable=1: col<=next_col, row<=next_row, visible<=visible_next; hsync/vsync/vblank/line_start/frame_start are decoded from next_col/next_row and registered.
  - enable=0: col=row=0, visible=0, line_start=frame_start=vblank=0, hsync=~HS_POL, vsync=~VS_POL.
- hsync active iff col in the H sync segment. vsync active iff row in the V sync segment, for the whole line (all columns).
- Delay pipeline: SYNC_DELAY registers per signal; reset and enable=0 do not flush it, so blanked values propagate naturally. SYNC_DELAY=0 means hsync_d=hsync, vsync_d=vsync, de_d=visible.
- Reset (async): next_col=next_row=col=row=0; visible, line_start, frame_start, vblank = 0; hsync/vsync and every hsync_d/vsync_d pipeline stage inactive (~POL); every de_d stage 0. visible_next follows the counters and reads 1 at (0,0).
- Restart:
  - First rising edge after reset release with enable=1 presents (0,0): visible=1, frame_start=1, line_start=1.
  - Deasserting enable mid-frame restarts the frame. There is no resume.
  - Reset mid-frame behaves identically to power-up reset.
- Simultaneous end-of-line and end-of-frame: both counters wrap on the same edge; frame_start and line_start assert together.

Test Plan:
Bench config for all scenarios: H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=3 (H_TOTAL=16); V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1 (V_TOTAL=8); HS_POL=0, VS_POL=0, SYNC_DELAY=2.
1. Reset, release, enable=1 -> 1st edge presents col=0,row=0,visible=1,frame_start=1; line_start repeats every 16 cycles, frame_start every 128 cycles.
2. Horizontal timing -> within any line: visible=1 for col 0..7, 0 for col 8..15; hsync=0 exactly at col 10..12, 1 elsewhere; col wraps 15->0 and row increments on the same edge.
3. Vertical timing -> vblank=1 for rows 4..7; vsync=0 for all 16 cycles of rows 5 and 6; row wraps 7->0 together with col 15->0, with frame_start=1 on that edge.
4. Delay check -> hsync_d/vsync_d/de_d equal hsync/vsync/visible from exactly 2 cycles earlier across a full frame; with SYNC_DELAY=0 they are identical to the undelayed outputs.
5. enable=0 at row=2,col=5 for 3 cycles -> next edge: col=row=0, visible=0, hsync=vsync=1. First edge after re-enable: col=0,row=0,frame_start=1.
6. Async reset asserted mid-line (row=1,col=9, no clock edge) -> outputs immediately hit reset values: hsync=vsync=1, visible=0, col=row=0, all delay stages inactive.

Source files
------------

// File: rtl/vga_timing_engine.sv
// Parametrised VGA raster timing: look-ahead pixel counters, a registered presented stage,
// and an optional delay line that keeps sync and data-enable aligned with a pixel pipeline.
module vga_timing_engine #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int HS_POL     = 0,
  parameter int VS_POL     = 0,
  parameter int SYNC_DELAY = 2,
  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int H_W       = $clog2(H_TOTAL),
  localparam int V_W       = $clog2(V_TOTAL)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  output logic [H_W-1:0] next_col,
  output logic [V_W-1:0] next_row,
  output logic           visible_next,
  output logic [H_W-1:0] col,
  output logic [V_W-1:0] row,
  output logic           visible,
  output logic           hsync,
  output logic           vsync,
  output logic           line_start,
  output logic           frame_start,
  output logic           vblank,
  output logic           hsync_d,
  output logic           vsync_d,
  output logic           de_d
);

  localparam logic [H_W-1:0] H_LAST     = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0] V_LAST     = V_W'(V_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT_END  = H_W'(H_ACTIVE);
  localparam logic [V_W-1:0] V_ACT_END  = V_W'(V_ACTIVE);
  localparam logic [H_W-1:0] HS_FIRST   = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] HS_LAST    = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [V_W-1:0] VS_FIRST   = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] VS_LAST    = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic           HS_ON      = 1'(HS_POL);
  localparam logic           VS_ON      = 1'(VS_POL);

  logic hs_zone_next;
  logic vs_zone_next;
  logic col_zero_next;
  logic row_zero_next;
  logic vblank_next;

  assign visible_next  = (next_col < H_ACT_END) && (next_row < V_ACT_END);
  assign hs_zone_next  = (next_col >= HS_FIRST) && (next_col <= HS_LAST);
  assign vs_zone_next  = (next_row >= VS_FIRST) && (next_row <= VS_LAST);
  assign col_zero_next = (next_col == '0);
  assign row_zero_next = (next_row == '0);
  assign vblank_next   = (next_row >= V_ACT_END);

  // Look-ahead counters: wrap on TOTAL-1 so they never hold TOTAL.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      next_col <= '0;
      next_row <= '0;
    end else if (!enable) begin
      next_col <= '0;
      next_row <= '0;
    end else if (next_col == H_LAST) begin
      next_col <= '0;
      next_row <= (next_row == V_LAST) ? '0 : next_row + 1'b1;
    end else begin
      next_col <= next_col + 1'b1;
    end
  end

  // Presented stage trails the look-ahead counters by exactly one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col         <= '0;
      row         <= '0;
      visible     <= 1'b0;
      hsync       <= ~HS_ON;
      vsync       <= ~VS_ON;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      vblank      <= 1'b0;
    end else if (!enable) begin
      col         <= '0;
      row         <= '0;
      visible     <= 1'b0;
      hsync       <= ~HS_ON;
      vsync       <= ~VS_ON;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      vblank      <= 1'b0;
    end else begin
      col         <= next_col;
      row         <= next_row;
      visible     <= visible_next;
      hsync       <= hs_zone_next ? HS_ON : ~HS_ON;
      vsync       <= vs_zone_next ? VS_ON : ~VS_ON;
      line_start  <= col_zero_next;
      frame_start <= col_zero_next && row_zero_next;
      vblank      <= vblank_next;
    end
  end

  generate
    if (SYNC_DELAY == 0) begin : g_no_delay
      assign hsync_d = hsync;
      assign vsync_d = vsync;
      assign de_d    = visible;
    end else begin : g_delay
      logic [SYNC_DELAY-1:0] hs_pipe;
      logic [SYNC_DELAY-1:0] vs_pipe;
      logic [SYNC_DELAY-1:0] de_pipe;

      // Not cleared by enable: blanked values simply flow through.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          hs_pipe <= {SYNC_DELAY{~HS_ON}};
          vs_pipe <= {SYNC_DELAY{~VS_ON}};
          de_pipe <= '0;
        end else begin
          hs_pipe[0] <= hsync;
          vs_pipe[0] <= vsync;
          de_pipe[0] <= visible;
          for (int i = 1; i < SYNC_DELAY; i++) begin
            hs_pipe[i] <= hs_pipe[i-1];
            vs_pipe[i] <= vs_pipe[i-1];
            de_pipe[i] <= de_pipe[i-1];
          end
        end
      end

      assign hsync_d = hs_pipe[SYNC_DELAY-1];
      assign vsync_d = vs_pipe[SYNC_DELAY-1];
      assign de_d    = de_pipe[SYNC_DELAY-1];
    end
  endgenerate

endmodule

// File: tb/tb_vga_timing_engine.sv
// Bench for vga_timing_engine on a 16x8 raster: directed vector table, restart and async-reset
// sequences, and a randomized-enable run checked against a raster-position reference model.
module tb_vga_timing_engine;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  bit   mon_on = 1'b0;

  always #5 clk = ~clk;

  logic [3:0] next_col, col, z_next_col, z_col;
  logic [2:0] next_row, row, z_next_row, z_row;
  logic visible_next, visible, hsync, vsync, line_start, frame_start, vblank;
  logic hsync_d, vsync_d, de_d;
  logic z_visible_next, z_visible, z_hsync, z_vsync, z_line_start, z_frame_start, z_vblank;
  logic z_hsync_d, z_vsync_d, z_de_d;

  vga_timing_engine #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(0), .VS_POL(0), .SYNC_DELAY(2)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .next_col(next_col), .next_row(next_row), .visible_next(visible_next),
    .col(col), .row(row), .visible(visible), .hsync(hsync), .vsync(vsync),
    .line_start(line_start), .frame_start(frame_start), .vblank(vblank),
    .hsync_d(hsync_d), .vsync_d(vsync_d), .de_d(de_d)
  );

  vga_timing_engine #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(0), .VS_POL(0), .SYNC_DELAY(0)
  ) dut0 (
    .clk(clk), .reset(reset), .enable(enable),
    .next_col(z_next_col), .next_row(z_next_row), .visible_next(z_visible_next),
    .col(z_col), .row(z_row), .visible(z_visible), .hsync(z_hsync), .vsync(z_vsync),
    .line_start(z_line_start), .frame_start(z_frame_start), .vblank(z_vblank),
    .hsync_d(z_hsync_d), .vsync_d(z_vsync_d), .de_d(z_de_d)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: raster position counted in pixels since the last restart (0..127).
  int npos = 0;
  int ppos = 0;
  bit blank = 1'b1;
  bit h1 = 1'b1, h2 = 1'b1, v1 = 1'b1, v2 = 1'b1, d1 = 1'b0, d2 = 1'b0;

  function automatic int m_col();   return blank ? 0 : ppos % 16;       endfunction
  function automatic int m_row();   return blank ? 0 : ppos / 16;       endfunction
  function automatic bit m_vis();   return !blank && m_col() < 8 && m_row() < 4; endfunction
  function automatic bit m_hs();    return blank ? 1'b1 : !(m_col() >= 10 && m_col() <= 12); endfunction
  function automatic bit m_vs();    return blank ? 1'b1 : !(m_row() == 5 || m_row() == 6);   endfunction
  function automatic bit m_ls();    return !blank && m_col() == 0;     endfunction
  function automatic bit m_fs();    return !blank && ppos == 0;        endfunction
  function automatic bit m_vb();    return !blank && m_row() >= 4;     endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      npos <= 0; ppos <= 0; blank <= 1'b1;
      h1 <= 1'b1; h2 <= 1'b1; v1 <= 1'b1; v2 <= 1'b1; d1 <= 1'b0; d2 <= 1'b0;
    end else begin
      h1 <= m_hs(); h2 <= h1;
      v1 <= m_vs(); v2 <= v1;
      d1 <= m_vis(); d2 <= d1;
      if (enable) begin
        ppos  <= npos;
        blank <= 1'b0;
        npos  <= (npos + 1) % 128;
      end else begin
        ppos  <= 0;
        blank <= 1'b1;
        npos  <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && mon_on) begin
      chk("next_col", next_col, npos % 16);
      chk("next_row", next_row, npos / 16);
      chk("visible_next", visible_next, int'((npos % 16) < 8 && (npos / 16) < 4));
      chk("col", col, m_col());
      chk("row", row, m_row());
      chk("visible", visible, m_vis());
      chk("hsync", hsync, m_hs());
      chk("vsync", vsync, m_vs());
      chk("line_start", line_start, m_ls());
      chk("frame_start", frame_start, m_fs());
      chk("vblank", vblank, m_vb());
      chk("hsync_d", hsync_d, h2);
      chk("vsync_d", vsync_d, v2);
      chk("de_d", de_d, d2);
      chk("nodelay_hsync_d", z_hsync_d, m_hs());
      chk("nodelay_vsync_d", z_vsync_d, m_vs());
      chk("nodelay_de_d", z_de_d, m_vis());
      chk("nodelay_col", z_col, m_col());
    end
  end

  typedef struct {
    bit en;
    int n;
    int col;
    int row;
    bit vis, hs, vs, ls, fs, vb;
  } vec_t;

  vec_t tbl[16];

  task automatic wait_pos(input int c, input int r);
    int k;
    k = 0;
    while (!(col == 4'(c) && row == 3'(r)) && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("reach_col%0d_row%0d", c, r), int'(k < 400), 1);
  endtask

  initial begin
    //           en  n  col row vis hs vs ls fs vb
    tbl[0]  = '{1,  1,  0, 0, 1, 1, 1, 1, 1, 0};
    tbl[1]  = '{1,  7,  7, 0, 1, 1, 1, 0, 0, 0};
    tbl[2]  = '{1,  1,  8, 0, 0, 1, 1, 0, 0, 0};
    tbl[3]  = '{1,  2, 10, 0, 0, 0, 1, 0, 0, 0};
    tbl[4]  = '{1,  2, 12, 0, 0, 0, 1, 0, 0, 0};
    tbl[5]  = '{1,  1, 13, 0, 0, 1, 1, 0, 0, 0};
    tbl[6]  = '{1,  2, 15, 0, 0, 1, 1, 0, 0, 0};
    tbl[7]  = '{1,  1,  0, 1, 1, 1, 1, 1, 0, 0};
    tbl[8]  = '{1, 64,  0, 5, 0, 1, 0, 1, 0, 1};
    tbl[9]  = '{1, 31, 15, 6, 0, 1, 0, 0, 0, 1};
    tbl[10] = '{1,  1,  0, 7, 0, 1, 1, 1, 0, 1};
    tbl[11] = '{1, 15, 15, 7, 0, 1, 1, 0, 0, 1};
    tbl[12] = '{1,  1,  0, 0, 1, 1, 1, 1, 1, 0};
    tbl[13] = '{1, 16,  0, 1, 1, 1, 1, 1, 0, 0};
    tbl[14] = '{0,  3,  0, 0, 0, 1, 1, 0, 0, 0};
    tbl[15] = '{1,  1,  0, 0, 1, 1, 1, 1, 1, 0};

    reset = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {col, row, visible, hsync, vsync, line_start, frame_start, vblank},
        {4'd0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    chk("rst_delay", {hsync_d, vsync_d, de_d}, 3'b110);
    chk("rst_visible_next", visible_next, 1);

    reset = 1'b0;
    mon_on = 1'b1;
    for (int i = 0; i < 16; i++) begin
      enable = tbl[i].en;
      repeat (tbl[i].n) @(negedge clk);
      chk($sformatf("vec%0d", i),
          {col, row, visible, hsync, vsync, line_start, frame_start, vblank},
          {4'(tbl[i].col), 3'(tbl[i].row), tbl[i].vis, tbl[i].hs, tbl[i].vs,
           tbl[i].ls, tbl[i].fs, tbl[i].vb});
    end

    // Restart mid-frame, then re-enable.
    wait_pos(5, 2);
    enable = 1'b0;
    @(negedge clk);
    chk("restart_blank", {col, row, visible, hsync, vsync}, {4'd0, 3'd0, 1'b0, 1'b1, 1'b1});
    repeat (2) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    chk("reenable_first", {col, row, frame_start, line_start, visible},
        {4'd0, 3'd0, 1'b1, 1'b1, 1'b1});

    for (int i = 0; i < 1500; i++) begin
      enable = ($urandom_range(0, 15) != 0);
      @(negedge clk);
    end
    enable = 1'b1;

    // Async reset between clock edges.
    wait_pos(9, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_outputs", {col, row, visible, hsync, vsync, next_col, next_row},
        {4'd0, 3'd0, 1'b0, 1'b1, 1'b1, 4'd0, 3'd0});
    chk("async_rst_delay", {hsync_d, vsync_d, de_d}, 3'b110);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_first", {col, row, frame_start, hsync_d, de_d},
        {4'd0, 3'd0, 1'b1, 1'b1, 1'b0});
    repeat (200) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
